riscv_wb_commit: RTL and testbench

RISCV_WB_COMMIT -- requirements
Module: riscv_wb_commit

---
 rtl/riscv_wb_commit.sv | 215 +++++++++++++++++++++
 tb/tb_riscv_wb_commit.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_wb_commit.sv
`default_nettype none
// ============================================================================
//  Module   : riscv_wb_commit
//  Purpose  : Write-back commit stage. Buffers results from NUM_CH producer
//             channels in small FIFOs, picks one head per cycle round-robin,
//             drives a registered register-file write port, counts retired
//             entries and reports operand forwarding / hazard status.
//  Revision : 1.0  initial release
// ============================================================================
module riscv_wb_commit #(
  parameter int XLEN   = 32,
  parameter int NUM_CH = 2,
  parameter int DEPTH  = 4
) (
  input  logic                     risc_clk,
  input  logic                     risc_rst,
  input  logic                     flush,
  input  logic [NUM_CH-1:0]        ch_valid,
  output logic [NUM_CH-1:0]        ch_ready,
  input  logic [2*NUM_CH-1:0]      ch_op,
  input  logic [5*NUM_CH-1:0]      ch_rd,
  input  logic [XLEN*NUM_CH-1:0]   ch_data,
  input  logic [4:0]               rs1,
  input  logic [4:0]               rs2,
  output logic [1:0]               fwd_a,
  output logic [1:0]               fwd_b,
  output logic                     wr_en,
  output logic [4:0]               wr_addr,
  output logic [XLEN-1:0]          wr_data,
  output logic [31:0]              retire_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [AW:0] C_FULL = (AW+1)'(DEPTH);

  // Per-channel FIFO storage; r_vld marks occupied slots so the hazard scan
  // does not need to reason about pointer distances.
  logic [1:0]       r_mem_op   [NUM_CH][DEPTH];
  logic [4:0]       r_mem_rd   [NUM_CH][DEPTH];
  logic [XLEN-1:0]  r_mem_data [NUM_CH][DEPTH];
  logic [DEPTH-1:0] r_vld      [NUM_CH];
  logic [AW-1:0]    r_wptr     [NUM_CH];
  logic [AW-1:0]    r_rptr     [NUM_CH];
  logic [AW:0]      r_cnt      [NUM_CH];
  logic [CW-1:0]    r_rr_ptr;

  logic             r_wr_en;
  logic [4:0]       r_wr_addr;
  logic [XLEN-1:0]  r_wr_data;
  logic [31:0]      r_retire_cnt;

  logic [NUM_CH-1:0] w_ready;
  logic [NUM_CH-1:0] w_push;
  logic [NUM_CH-1:0] w_pop;
  logic [DEPTH-1:0]  w_vld_set [NUM_CH];
  logic [DEPTH-1:0]  w_vld_clr [NUM_CH];
  logic              w_gnt_vld;
  logic [CW-1:0]     w_gnt_idx;
  logic [CW-1:0]     w_rr_next;
  logic [1:0]        w_head_op;
  logic [4:0]        w_head_rd;
  logic [XLEN-1:0]   w_head_data;
  logic              w_haz_a;
  logic              w_haz_b;

  // Accept only with free space; a pop in the same cycle gives no credit.
  always_comb begin
    w_ready = '0;
    w_push  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_ready[i] = (r_cnt[i] != C_FULL) && !flush && !risc_rst;
      w_push[i]  = ch_valid[i] && w_ready[i];
    end
  end

  assign ch_ready = w_ready;

  // Round-robin search for the first non-empty head starting at r_rr_ptr.
  always_comb begin
    logic [CW-1:0] v_idx;
    v_idx     = '0;
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    w_pop     = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      v_idx = CW'((int'(r_rr_ptr) + k) % NUM_CH);
      if (!w_gnt_vld && (r_cnt[v_idx] != '0)) begin
        w_gnt_vld = 1'b1;
        w_gnt_idx = v_idx;
      end
    end
    if (w_gnt_vld) begin
      w_pop[w_gnt_idx] = 1'b1;
    end
  end

  assign w_rr_next   = (w_gnt_idx == CW'(NUM_CH - 1)) ? '0 : w_gnt_idx + CW'(1);
  assign w_head_op   = r_mem_op[w_gnt_idx][r_rptr[w_gnt_idx]];
  assign w_head_rd   = r_mem_rd[w_gnt_idx][r_rptr[w_gnt_idx]];
  assign w_head_data = r_mem_data[w_gnt_idx][r_rptr[w_gnt_idx]];

  // One-hot slot masks for the occupancy bits touched this cycle.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      w_vld_set[i] = w_push[i] ? (DEPTH'(1) << r_wptr[i]) : '0;
      w_vld_clr[i] = w_pop[i]  ? (DEPTH'(1) << r_rptr[i]) : '0;
    end
  end

  // FIFO payload storage; no reset needed since r_vld/r_cnt qualify it.
  always_ff @(posedge risc_clk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (w_push[i]) begin
        r_mem_op[i][r_wptr[i]]   <= ch_op[2*i +: 2];
        r_mem_rd[i][r_wptr[i]]   <= ch_rd[5*i +: 5];
        r_mem_data[i][r_wptr[i]] <= ch_data[XLEN*i +: XLEN];
      end
    end
  end

  // FIFO pointers, occupancy and slot-valid bits; flush empties everything.
  always_ff @(posedge risc_clk or posedge risc_rst) begin
    if (risc_rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_wptr[i] <= '0;
        r_rptr[i] <= '0;
        r_cnt[i]  <= '0;
        r_vld[i]  <= '0;
      end
    end else if (flush) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_wptr[i] <= '0;
        r_rptr[i] <= '0;
        r_cnt[i]  <= '0;
        r_vld[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (w_push[i]) r_wptr[i] <= r_wptr[i] + AW'(1);
        if (w_pop[i])  r_rptr[i] <= r_rptr[i] + AW'(1);
        r_vld[i] <= (r_vld[i] | w_vld_set[i]) & ~w_vld_clr[i];
        case ({w_push[i], w_pop[i]})
          2'b10:   r_cnt[i] <= r_cnt[i] + (AW+1)'(1);
          2'b01:   r_cnt[i] <= r_cnt[i] - (AW+1)'(1);
          default: r_cnt[i] <= r_cnt[i];
        endcase
      end
    end
  end

  // Round-robin pointer advances past each grantee; flush leaves it alone.
  always_ff @(posedge risc_clk or posedge risc_rst) begin
    if (risc_rst) begin
      r_rr_ptr <= '0;
    end else if (!flush && w_gnt_vld) begin
      r_rr_ptr <= w_rr_next;
    end
  end

  // Registered write port and retire counter; only writing ops with rd!=0
  // raise wr_en, address/data hold otherwise.
  always_ff @(posedge risc_clk or posedge risc_rst) begin
    if (risc_rst) begin
      r_wr_en      <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
      r_retire_cnt <= '0;
    end else if (flush) begin
      r_wr_en <= 1'b0;
    end else if (w_gnt_vld) begin
      r_retire_cnt <= r_retire_cnt + 32'd1;
      if (!w_head_op[1] && (w_head_rd != 5'd0)) begin
        r_wr_en   <= 1'b1;
        r_wr_addr <= w_head_rd;
        r_wr_data <= w_head_op[0] ? (w_head_data + XLEN'(4)) : w_head_data;
      end else begin
        r_wr_en <= 1'b0;
      end
    end else begin
      r_wr_en <= 1'b0;
    end
  end

  assign wr_en      = r_wr_en;
  assign wr_addr    = r_wr_addr;
  assign wr_data    = r_wr_data;
  assign retire_cnt = r_retire_cnt;

  // Scan every occupied slot for a pending write to either source register.
  always_comb begin
    w_haz_a = 1'b0;
    w_haz_b = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      for (int j = 0; j < DEPTH; j++) begin
        if (r_vld[i][j] && !r_mem_op[i][j][1]) begin
          if (r_mem_rd[i][j] == rs1) w_haz_a = 1'b1;
          if (r_mem_rd[i][j] == rs2) w_haz_b = 1'b1;
        end
      end
    end
  end

  // Pending hazard beats forwarding from the write port; x0 never forwards.
  always_comb begin
    if ((rs1 != 5'd0) && w_haz_a)                          fwd_a = 2'b10;
    else if ((rs1 != 5'd0) && r_wr_en && (r_wr_addr == rs1)) fwd_a = 2'b01;
    else                                                   fwd_a = 2'b00;
    if ((rs2 != 5'd0) && w_haz_b)                          fwd_b = 2'b10;
    else if ((rs2 != 5'd0) && r_wr_en && (r_wr_addr == rs2)) fwd_b = 2'b01;
    else                                                   fwd_b = 2'b00;
  end

endmodule
`default_nettype wire

// File: tb/tb_riscv_wb_commit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_riscv_wb_commit
//  Purpose  : Self-checking bench for riscv_wb_commit against a queue-based
//             behavioural model of the commit stage.
//  Revision : 1.0  initial release
// ============================================================================
module tb_riscv_wb_commit;

  localparam int XLEN   = 32;
  localparam int NUM_CH = 2;
  localparam int DEPTH  = 4;

  logic                   risc_clk = 1'b0;
  logic                   risc_rst;
  logic                   flush;
  logic [NUM_CH-1:0]      ch_valid;
  logic [NUM_CH-1:0]      ch_ready;
  logic [2*NUM_CH-1:0]    ch_op;
  logic [5*NUM_CH-1:0]    ch_rd;
  logic [XLEN*NUM_CH-1:0] ch_data;
  logic [4:0]             rs1;
  logic [4:0]             rs2;
  logic [1:0]             fwd_a;
  logic [1:0]             fwd_b;
  logic                   wr_en;
  logic [4:0]             wr_addr;
  logic [XLEN-1:0]        wr_data;
  logic [31:0]            retire_cnt;

  int checks   = 0;
  int failures = 0;

  // Model state: one queue of {op,rd,data} per channel plus the visible outputs.
  logic [38:0] mq [NUM_CH][$];
  int          m_rr;
  logic        m_wr_en;
  logic [4:0]  m_wr_addr;
  logic [31:0] m_wr_data;
  logic [31:0] m_retire;

  riscv_wb_commit #(.XLEN(XLEN), .NUM_CH(NUM_CH), .DEPTH(DEPTH)) dut (
    .risc_clk(risc_clk), .risc_rst(risc_rst), .flush(flush),
    .ch_valid(ch_valid), .ch_ready(ch_ready), .ch_op(ch_op), .ch_rd(ch_rd),
    .ch_data(ch_data), .rs1(rs1), .rs2(rs2), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .retire_cnt(retire_cnt)
  );

  always #5 risc_clk = ~risc_clk;

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) mq[c].delete();
    m_rr = 0; m_wr_en = 1'b0; m_wr_addr = '0; m_wr_data = '0; m_retire = '0;
  endtask

  function automatic logic [1:0] exp_fwd(input logic [4:0] rs);
    logic hz;
    logic [38:0] e;
    hz = 1'b0;
    for (int c = 0; c < NUM_CH; c++)
      for (int k = 0; k < mq[c].size(); k++) begin
        e = mq[c][k];
        if (!e[38] && e[36:32] == rs) hz = 1'b1;
      end
    if (rs != 5'd0 && hz) return 2'b10;
    if (rs != 5'd0 && m_wr_en && m_wr_addr == rs) return 2'b01;
    return 2'b00;
  endfunction

  // What the next clock edge does, expressed on queues.
  task automatic model_edge(input logic [NUM_CH-1:0] push, input logic fl);
    logic [38:0] e;
    bit found;
    int c;
    if (fl) begin
      for (int ch = 0; ch < NUM_CH; ch++) mq[ch].delete();
      m_wr_en = 1'b0;
    end else begin
      found = 0;
      for (int k = 0; k < NUM_CH; k++) begin
        c = (m_rr + k) % NUM_CH;
        if (!found && mq[c].size() > 0) begin
          found = 1;
          e = mq[c].pop_front();
          m_retire = m_retire + 32'd1;
          if (!e[38] && e[36:32] != 5'd0) begin
            m_wr_en   = 1'b1;
            m_wr_addr = e[36:32];
            m_wr_data = e[37] ? e[31:0] + 32'd4 : e[31:0];
          end else begin
            m_wr_en = 1'b0;
          end
          m_rr = (c + 1) % NUM_CH;
        end
      end
      if (!found) m_wr_en = 1'b0;
      for (int ch = 0; ch < NUM_CH; ch++)
        if (push[ch]) mq[ch].push_back({ch_op[2*ch +: 2], ch_rd[5*ch +: 5], ch_data[32*ch +: 32]});
    end
  endtask

  task automatic set_ch(input int c, input logic v, input logic [1:0] op,
                        input logic [4:0] rd, input logic [31:0] d);
    ch_valid[c]       = v;
    ch_op[2*c +: 2]   = op;
    ch_rd[5*c +: 5]   = rd;
    ch_data[32*c +: 32] = d;
  endtask

  task automatic idle_inputs();
    ch_valid = '0; ch_op = '0; ch_rd = '0; ch_data = '0; flush = 1'b0;
  endtask

  // One clock: inputs already applied at the falling edge.
  task automatic cycle();
    logic [NUM_CH-1:0] exp_rdy;
    logic [1:0] efa, efb;
    #1;
    for (int c = 0; c < NUM_CH; c++) exp_rdy[c] = !flush && (mq[c].size() < DEPTH);
    efa = exp_fwd(rs1);
    efb = exp_fwd(rs2);
    checks++;
    if (ch_ready !== exp_rdy) begin
      failures++; $display("FAIL ch_ready got=%b exp=%b t=%0t", ch_ready, exp_rdy, $time);
    end
    checks++;
    if (fwd_a !== efa) begin
      failures++; $display("FAIL fwd_a rs1=%0d got=%b exp=%b t=%0t", rs1, fwd_a, efa, $time);
    end
    checks++;
    if (fwd_b !== efb) begin
      failures++; $display("FAIL fwd_b rs2=%0d got=%b exp=%b t=%0t", rs2, fwd_b, efb, $time);
    end
    model_edge(ch_valid & exp_rdy, flush);
    @(posedge risc_clk);
    @(negedge risc_clk);
    checks++;
    if (wr_en !== m_wr_en) begin
      failures++; $display("FAIL wr_en got=%b exp=%b t=%0t", wr_en, m_wr_en, $time);
    end
    checks++;
    if (wr_addr !== m_wr_addr) begin
      failures++; $display("FAIL wr_addr got=%0d exp=%0d t=%0t", wr_addr, m_wr_addr, $time);
    end
    checks++;
    if (wr_data !== m_wr_data) begin
      failures++; $display("FAIL wr_data got=%h exp=%h t=%0t", wr_data, m_wr_data, $time);
    end
    checks++;
    if (retire_cnt !== m_retire) begin
      failures++; $display("FAIL retire_cnt got=%0d exp=%0d t=%0t", retire_cnt, m_retire, $time);
    end
  endtask

  task automatic drain(input int n);
    idle_inputs();
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic test_reset();
    risc_rst = 1'b1; idle_inputs(); rs1 = 5'd3; rs2 = 5'd4;
    #1;
    checks++;
    if ({wr_en, wr_addr, wr_data, retire_cnt, ch_ready, fwd_a, fwd_b} !== '0) begin
      failures++;
      $display("FAIL reset_state wr_en=%b addr=%0d data=%h ret=%0d rdy=%b fa=%b fb=%b exp=all zero",
               wr_en, wr_addr, wr_data, retire_cnt, ch_ready, fwd_a, fwd_b);
    end
    @(negedge risc_clk);
    risc_rst = 1'b0;
    model_reset();
  endtask

  task automatic test_basic_write();
    idle_inputs(); rs1 = '0; rs2 = '0;
    set_ch(0, 1'b1, 2'b00, 5'd5, 32'h1234);
    cycle();
    idle_inputs();
    cycle();
    checks++;
    if (wr_en !== 1'b1 || wr_addr !== 5'd5 || wr_data !== 32'h1234 || retire_cnt !== 32'd1) begin
      failures++;
      $display("FAIL basic_write en=%b addr=%0d data=%h ret=%0d exp=1/5/00001234/1",
               wr_en, wr_addr, wr_data, retire_cnt);
    end
  endtask

  task automatic test_link_and_x0();
    logic [31:0] r0;
    r0 = retire_cnt;
    idle_inputs();
    set_ch(0, 1'b1, 2'b01, 5'd1, 32'hFFFF_FFFC);
    set_ch(1, 1'b1, 2'b00, 5'd0, 32'hAAAA_5555);
    cycle();
    idle_inputs();
    cycle();
    checks++;
    if (wr_en !== 1'b0 || retire_cnt !== r0 + 32'd1) begin
      failures++; $display("FAIL rd0_write en=%b ret=%0d exp=0/%0d", wr_en, retire_cnt, r0 + 32'd1);
    end
    cycle();
    checks++;
    if (wr_en !== 1'b1 || wr_addr !== 5'd1 || wr_data !== 32'h0 || retire_cnt !== r0 + 32'd2) begin
      failures++;
      $display("FAIL link_wrap en=%b addr=%0d data=%h ret=%0d exp=1/1/00000000/%0d",
               wr_en, wr_addr, wr_data, retire_cnt, r0 + 32'd2);
    end
    drain(2);
  endtask

  task automatic test_back_to_back();
    int full_seen;
    full_seen = 0;
    for (int n = 0; n < 16; n++) begin
      set_ch(0, 1'b1, 2'b00, 5'(1 + n % 7), $urandom);
      set_ch(1, 1'b1, 2'b00, 5'(8 + n % 7), $urandom);
      #1;
      if (ch_ready != 2'b11) full_seen++;
      #0;
      cycle();
    end
    checks++;
    if (full_seen == 0) begin
      failures++; $display("FAIL backpressure full_cycles got=%0d exp=>0", full_seen);
    end
    drain(10);
  endtask

  task automatic test_hazard();
    idle_inputs(); rs1 = 5'd0; rs2 = 5'd0;
    set_ch(0, 1'b1, 2'b00, 5'd7, 32'hCAFE);
    cycle();
    idle_inputs(); rs1 = 5'd7;
    #1;
    checks++;
    if (fwd_a !== 2'b10) begin
      failures++; $display("FAIL hazard_pending got=%b exp=10", fwd_a);
    end
    cycle();
    rs1 = 5'd7;
    #1;
    checks++;
    if (fwd_a !== 2'b01) begin
      failures++; $display("FAIL hazard_forward got=%b exp=01", fwd_a);
    end
    rs1 = 5'd0;
    #1;
    checks++;
    if (fwd_a !== 2'b00) begin
      failures++; $display("FAIL hazard_x0 got=%b exp=00", fwd_a);
    end
    cycle();
  endtask

  task automatic test_flush();
    logic [31:0] r0;
    idle_inputs(); rs1 = 5'd0; rs2 = 5'd0;
    for (int n = 0; n < 2; n++) begin
      set_ch(0, 1'b1, 2'b00, 5'd9, 32'h100 + n);
      set_ch(1, 1'b1, 2'b00, 5'd10, 32'h200 + n);
      cycle();
    end
    idle_inputs();
    set_ch(0, 1'b1, 2'b00, 5'd9, 32'h3333);
    flush = 1'b1;
    r0 = m_retire;
    cycle();
    idle_inputs();
    rs1 = 5'd9; rs2 = 5'd10;
    for (int n = 0; n < 3; n++) begin
      #1;
      checks++;
      if (wr_en !== 1'b0 || retire_cnt !== r0 || fwd_a !== 2'b00 || fwd_b !== 2'b00) begin
        failures++;
        $display("FAIL flush_empty en=%b ret=%0d fa=%b fb=%b exp=0/%0d/00/00",
                 wr_en, retire_cnt, fwd_a, fwd_b, r0);
      end
      cycle();
    end
  endtask

  task automatic test_random(input int n);
    for (int i = 0; i < n; i++) begin
      for (int c = 0; c < NUM_CH; c++)
        set_ch(c, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
               5'($urandom_range(0, 7)), $urandom);
      flush = ($urandom_range(0, 19) == 0);
      rs1 = 5'($urandom_range(0, 7));
      rs2 = 5'($urandom_range(0, 7));
      cycle();
    end
    drain(6);
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 8; i++) begin
      for (int c = 0; c < NUM_CH; c++)
        set_ch(c, 1'b1, 2'b00, 5'($urandom_range(1, 7)), $urandom);
      rs1 = 5'd3; rs2 = 5'd5;
      cycle();
    end
    #2;
    risc_rst = 1'b1;
    #1;
    checks++;
    if ({wr_en, wr_addr, wr_data, retire_cnt, ch_ready, fwd_a, fwd_b} !== '0) begin
      failures++;
      $display("FAIL async_reset en=%b addr=%0d data=%h ret=%0d rdy=%b fa=%b fb=%b exp=all zero",
               wr_en, wr_addr, wr_data, retire_cnt, ch_ready, fwd_a, fwd_b);
    end
    @(negedge risc_clk);
    risc_rst = 1'b0;
    idle_inputs();
    model_reset();
    test_random(60);
  endtask

  initial begin
    test_reset();
    test_basic_write();
    test_link_and_x0();
    test_back_to_back();
    test_hazard();
    test_flush();
    test_random(400);
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
